// File: rtl/rx_pkg.sv
// rx_pkg: shared types, widths and helpers for the receive-chain peak search
package rx_pkg;
    localparam int CORR_W_DEF = 41;
    localparam int TIME_W_DEF = 32;
    typedef enum logic [2:0] {S_IDLE, S_WINDOW, S_SCAN, S_HOLD, S_HOLDOFF} state_t;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/rx_peak_channel_max.sv
// rx_peak_channel_max: running maximum of one correlator channel and its timestamp
module rx_peak_channel_max import rx_pkg::*; #(
    parameter int CORR_W = CORR_W_DEF,
    parameter int TIME_W = TIME_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upd,
    input  logic                     first,
    input  logic signed [CORR_W-1:0] corr,
    input  logic [TIME_W-1:0]        t,
    output logic signed [CORR_W-1:0] max_o,
    output logic [TIME_W-1:0]        time_o
);
    logic signed [CORR_W-1:0] max_q, max_d, base;
    logic [TIME_W-1:0] time_q, time_d;
    logic hit;
    // The arming sample is compared against a cleared register; later samples against the running max
    always_comb begin
        base = first ? '0 : max_q;
        hit = upd && (corr > base);
        max_d = hit ? corr : (upd && first) ? '0 : max_q;
        time_d = hit ? t : (upd && first) ? '0 : time_q;
    end
    // Max/time register pair
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= '0;
            time_q <= '0;
        end else begin
            max_q <= max_d;
            time_q <= time_d;
        end
    end
    assign max_o = max_q;
    assign time_o = time_q;
endmodule

// File: rtl/rx_peak_arbiter.sv
// rx_peak_arbiter: windowed per-channel peak search, best/second scan and valid/ack result handshake
module rx_peak_arbiter import rx_pkg::*; #(
    parameter int N_SEQ        = 16,
    parameter int CORR_W       = CORR_W_DEF,
    parameter int TIME_W       = TIME_W_DEF,
    parameter int WINDOW_SIZE  = 22100,
    parameter int THRESHOLD    = 800,
    parameter int HOLDOFF      = 1000,
    parameter int MARGIN_SHIFT = 1
) (
    input  logic                       crx_clk,
    input  logic                       rrx_rst,
    input  logic                       erx_en,
    input  logic                       inew_sample_trigger,
    input  logic signed [15:0]         isample_filtered,
    input  logic [TIME_W-1:0]          icurrent_time,
    input  logic [N_SEQ*CORR_W-1:0]    icorr_flat,
    input  logic                       iresult_acquired,
    output logic signed [CORR_W-1:0]   o_peak,
    output logic signed [CORR_W-1:0]   o_second_peak,
    output logic [clog2(N_SEQ)-1:0]    o_seq,
    output logic [TIME_W-1:0]          o_time,
    output logic                       o_ambiguous,
    output logic                       o_valid,
    output logic                       o_busy
);
    localparam int SW = clog2(N_SEQ);
    localparam int IW = clog2(N_SEQ + 1);
    state_t state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [SW-1:0] sidx, seq_q, seq_d;
    logic signed [CORR_W-1:0] peak_q, peak_d, second_q, second_d, cur;
    logic [TIME_W-1:0] time_q, time_d;
    logic amb_q, amb_d, valid_q, valid_d, enter_scan;
    logic rst, arm, upd, first;
    logic signed [CORR_W-1:0] max_v [N_SEQ];
    logic [TIME_W-1:0] tim_v [N_SEQ];
    logic signed [CORR_W:0] pk_x, sc_x, thr;
    assign rst = rrx_rst | ~erx_en;
    assign arm = inew_sample_trigger && (32'(isample_filtered) > THRESHOLD);
    assign first = state_q == S_IDLE;
    assign upd = first ? arm : (state_q == S_WINDOW) && inew_sample_trigger;
    assign sidx = idx_q[SW-1:0];
    assign cur = max_v[sidx];
    assign pk_x = (CORR_W+1)'(peak_q);
    assign sc_x = (CORR_W+1)'(second_q);
    assign thr = sc_x + (sc_x >>> MARGIN_SHIFT);
    for (genvar k = 0; k < N_SEQ; k++) begin : g_ch
        rx_peak_channel_max #(.CORR_W(CORR_W), .TIME_W(TIME_W)) u_ch (
            .clk(crx_clk), .rst(rst), .upd(upd), .first(first),
            .corr(icorr_flat[k*CORR_W +: CORR_W]), .t(icurrent_time),
            .max_o(max_v[k]), .time_o(tim_v[k])
        );
    end
    // Next-state, counters, scan datapath and handshake
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        seq_d = seq_q;
        peak_d = peak_q;
        second_d = second_q;
        time_d = time_q;
        amb_d = amb_q;
        valid_d = valid_q;
        enter_scan = 1'b0;
        case (state_q)
            S_IDLE: if (arm) begin
                cnt_d = 32'd1;
                state_d = S_WINDOW;
                enter_scan = WINDOW_SIZE == 1;
            end
            S_WINDOW: if (inew_sample_trigger) begin
                cnt_d = cnt_q + 32'd1;
                enter_scan = cnt_q + 32'd1 == 32'(WINDOW_SIZE);
            end
            S_SCAN: if (idx_q == IW'(N_SEQ)) begin
                amb_d = (second_q != '0) && (pk_x < thr);
                valid_d = 1'b1;
                state_d = S_HOLD;
            end else begin
                idx_d = idx_q + 1'b1;
                if (cur > peak_q) begin
                    second_d = peak_q;
                    peak_d = cur;
                    seq_d = sidx;
                    time_d = tim_v[sidx];
                end else if (cur > second_q) begin
                    second_d = cur;
                end
            end
            S_HOLD: if (iresult_acquired) begin
                valid_d = 1'b0;
                cnt_d = '0;
                state_d = HOLDOFF > 0 ? S_HOLDOFF : S_IDLE;
            end
            S_HOLDOFF: if (inew_sample_trigger) begin
                cnt_d = cnt_q + 32'd1;
                state_d = cnt_q + 32'd1 == 32'(HOLDOFF) ? S_IDLE : S_HOLDOFF;
            end
            default: state_d = S_IDLE;
        endcase
        if (enter_scan) begin
            state_d = S_SCAN;
            idx_d = '0;
            seq_d = '0;
            peak_d = '0;
            second_d = '0;
            time_d = '0;
            amb_d = 1'b0;
        end
    end
    // State and result registers; disable acts as a synchronous reset
    always_ff @(posedge crx_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            seq_q <= '0;
            peak_q <= '0;
            second_q <= '0;
            time_q <= '0;
            amb_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seq_q <= seq_d;
            peak_q <= peak_d;
            second_q <= second_d;
            time_q <= time_d;
            amb_q <= amb_d;
            valid_q <= valid_d;
        end
    end
    assign o_peak = peak_q;
    assign o_second_peak = second_q;
    assign o_seq = seq_q;
    assign o_time = time_q;
    assign o_ambiguous = amb_q;
    assign o_valid = valid_q;
    assign o_busy = state_q != S_IDLE;
endmodule

// File: tb/tb_rx_peak_arbiter.sv
// tb_rx_peak_arbiter: directed windows checked against a window-level behavioural model
module tb_rx_peak_arbiter;
    localparam int N = 4, CW = 41, TW = 32, WS = 8, HO = 3;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, en, trig, ack;
    logic signed [15:0] samp;
    logic [TW-1:0] tnow;
    logic [N*CW-1:0] cflat;
    logic signed [CW-1:0] o_peak, o_second_peak;
    logic [1:0] o_seq;
    logic [TW-1:0] o_time;
    logic o_ambiguous, o_valid, o_busy;

    rx_peak_arbiter #(.N_SEQ(N), .CORR_W(CW), .TIME_W(TW), .WINDOW_SIZE(WS),
                      .THRESHOLD(800), .HOLDOFF(HO), .MARGIN_SHIFT(1)) dut (
        .crx_clk(clk), .rrx_rst(rst), .erx_en(en), .inew_sample_trigger(trig),
        .isample_filtered(samp), .icurrent_time(tnow), .icorr_flat(cflat),
        .iresult_acquired(ack), .o_peak(o_peak), .o_second_peak(o_second_peak),
        .o_seq(o_seq), .o_time(o_time), .o_ambiguous(o_ambiguous),
        .o_valid(o_valid), .o_busy(o_busy)
    );

    int n_chk = 0, n_pass = 0;
    bit chk_on = 0;
    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // stimulus table: wc[channel][sample], sample j carries time 0xD0 + 16*j
    longint wc [N][WS];
    function automatic logic [TW-1:0] wt(input int j);
        return 32'h0D0 + 32'(j * 16);
    endfunction
    task automatic fill(input longint base);
        for (int k = 0; k < N; k++)
            for (int j = 0; j < WS; j++) wc[k][j] = base + 10 * k + j;
    endtask

    // model: phase 0 idle, 1 window, 2 scanning, 3 result held, 4 hold-off
    int ph = 0, cyc = 0, e0 = 0, ns = 0, hc = 0;
    longint mc [N][16];
    logic [TW-1:0] mt [16];
    longint e_peak = 0, e_second = 0;
    int e_seq = 0;
    logic [TW-1:0] e_time = '0;
    bit e_amb = 0, e_valid = 0;

    function automatic void record();
        for (int k = 0; k < N; k++) mc[k][ns] = $signed(cflat[k*CW +: CW]);
        mt[ns] = tnow;
        ns++;
    endfunction

    function automatic void compute();
        longint mx [N];
        logic [TW-1:0] tm [N];
        for (int k = 0; k < N; k++) begin
            mx[k] = 0;
            tm[k] = '0;
            for (int j = 0; j < ns; j++)
                if (mc[k][j] > mx[k]) begin
                    mx[k] = mc[k][j];
                    tm[k] = mt[j];
                end
        end
        e_peak = 0;
        for (int k = 0; k < N; k++) if (mx[k] > e_peak) e_peak = mx[k];
        e_seq = 0;
        for (int k = N - 1; k >= 0; k--) if (e_peak > 0 && mx[k] == e_peak) e_seq = k;
        e_time = e_peak > 0 ? tm[e_seq] : '0;
        e_second = 0;
        for (int k = 0; k < N; k++) if (k != e_seq && mx[k] > e_second) e_second = mx[k];
        e_amb = e_second != 0 && e_peak < e_second + e_second / 2;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst || !en) begin
            ph = 0;
            e_peak = 0; e_second = 0; e_seq = 0; e_time = '0; e_amb = 0; e_valid = 0;
        end else begin
            case (ph)
                0: if (trig && int'(samp) > 800) begin
                    ph = 1; ns = 0; record();
                    if (ns == WS) begin ph = 2; e0 = cyc; end
                end
                1: if (trig) begin
                    record();
                    if (ns == WS) begin ph = 2; e0 = cyc; end
                end
                2: if (cyc == e0 + N + 1) begin compute(); e_valid = 1; ph = 3; end
                3: if (ack) begin e_valid = 0; ph = 4; hc = 0; end
                4: if (trig) begin hc++; if (hc == HO) ph = 0; end
                default: ph = 0;
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("busy", o_busy, longint'(ph != 0));
            chk("valid", o_valid, e_valid);
            if (ph != 2) begin
                chk("peak", o_peak, e_peak);
                chk("second", o_second_peak, e_second);
                chk("seq", o_seq, e_seq);
                chk("time", o_time, e_time);
                chk("amb", o_ambiguous, e_amb);
            end
        end
    end

    task automatic strobe(input int s, input int j);
        @(posedge clk); #2;
        trig = 1'b1;
        samp = 16'(s);
        tnow = wt(j);
        for (int k = 0; k < N; k++) cflat[k*CW +: CW] = CW'(wc[k][j]);
        @(posedge clk); #2;
        trig = 1'b0;
    endtask

    task automatic run_win();
        strobe(801, 0);
        for (int j = 1; j < WS; j++) strobe(0, j);
    endtask

    task automatic expect_res(input string tg, input longint pk, input longint sc,
                              input int sq, input longint tm, input int amb);
        repeat (N + 1) @(posedge clk);
        #2;
        chk({tg, "_valid"}, o_valid, 1);
        chk({tg, "_peak"}, o_peak, pk);
        chk({tg, "_second"}, o_second_peak, sc);
        chk({tg, "_seq"}, o_seq, sq);
        chk({tg, "_time"}, o_time, tm);
        chk({tg, "_amb"}, o_ambiguous, amb);
    endtask

    task automatic ack_pulse();
        @(posedge clk); #2 ack = 1'b1;
        @(posedge clk); #2 ack = 1'b0;
    endtask

    task automatic ack_clear();
        ack_pulse();
        chk("ack_valid_low", o_valid, 0);
        repeat (HO) strobe(0, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; trig = 1'b0; ack = 1'b0; samp = '0; tnow = '0; cflat = '0;
        fill(100);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_peak", o_peak, 0);
        chk("rst_second", o_second_peak, 0);
        chk("rst_seq", o_seq, 0);
        chk("rst_time", o_time, 0);
        chk("rst_amb", o_ambiguous, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk_on = 1;
        rst = 1'b0;
        strobe(800, 0);
        chk("no_arm_at_800", o_busy, 0);

        fill(100); wc[0][1] = 1000; wc[2][3] = 5000;
        run_win();
        expect_res("single", 5000, 1000, 2, 'h100, 0);
        ack_clear();

        fill(100); wc[1][1] = 3000; wc[3][4] = 3000;
        run_win();
        expect_res("tie", 3000, 3000, 1, 'h0E0, 1);
        ack_clear();

        fill(100); wc[0][5] = 4400; wc[3][2] = 3000;
        run_win();
        expect_res("m4400", 4400, 3000, 0, 'h120, 1);
        ack_clear();

        fill(100); wc[0][5] = 4500; wc[3][2] = 3000;
        run_win();
        expect_res("m4500", 4500, 3000, 0, 'h120, 0);
        repeat (20) @(posedge clk);
        #2;
        chk("hold_valid", o_valid, 1);
        chk("hold_peak", o_peak, 4500);
        ack_pulse();
        chk("ack_valid_low", o_valid, 0);
        repeat (HO) strobe(900, 0);
        chk("holdoff_done_idle", o_busy, 0);

        fill(100); wc[2][6] = 7000;
        strobe(900, 0);
        chk("rearm_busy", o_busy, 1);
        for (int j = 1; j < 4; j++) strobe(0, j);
        @(posedge clk); #2;
        trig = 1'b1; en = 1'b0;
        @(posedge clk); #2;
        trig = 1'b0;
        chk("dis_busy", o_busy, 0);
        chk("dis_valid", o_valid, 0);
        chk("dis_peak", o_peak, 0);
        chk("dis_time", o_time, 0);
        en = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        chk("dis_no_valid", o_valid, 0);

        fill(100); wc[3][7] = 2000;
        run_win();
        expect_res("reen", 2000, 127, 3, 'h140, 0);
        ack_clear();

        fill(-500);
        run_win();
        expect_res("neg", 0, 0, 0, 0, 0);
        ack_clear();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
